ex_muldiv_unit: RTL and testbench

//  EX-stage iterative multiply/divide unit with architectural HI/LO registers.

---
 rtl/ex_muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : EX-stage iterative multiply/divide with architectural HI/LO
//            (radix-2 shift-add multiply, restoring divide, fixed latency).
// Revision : 1.0
// ============================================================================
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [2:0]       MulDivOp,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc;       // MUL: {partial product, multiplier}; DIV: low half is quotient
  logic [WIDTH-1:0]   opb;       // multiplicand / divisor magnitude
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   a_raw;
  logic               neg_q, neg_r, div_zero, is_div;

  logic               accept, last, signed_op, div_bit;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_shift, rem_diff, rem_nxt;

  assign accept    = Start && !Flush && (state == IDLE);
  assign last      = (counter == CW'(WIDTH-1));
  assign Busy      = (state != IDLE);
  assign signed_op = !MulDivOp[0];
  assign a_mag     = (signed_op && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign b_mag     = (signed_op && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign rem_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opb};
  assign div_bit   = (rem_shift >= {1'b0, opb});
  assign rem_nxt   = div_bit ? rem_diff : rem_shift;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && MulDivOp[2:1] == 2'b00)      state_nxt = MUL;
        else if (accept && MulDivOp[2:1] == 2'b01) state_nxt = DIV;
      end
      MUL, DIV: if (last) state_nxt = FIX;
      FIX:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      HI       <= '0;
      LO       <= '0;
      Done     <= 1'b0;
      counter  <= '0;
      acc      <= '0;
      opb      <= '0;
      rem      <= '0;
      a_raw    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      is_div   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!MulDivOp[2]) begin
              acc      <= {{WIDTH{1'b0}}, a_mag};
              opb      <= b_mag;
              rem      <= '0;
              counter  <= '0;
              a_raw    <= OperandA;
              neg_q    <= signed_op && (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
              neg_r    <= signed_op && OperandA[WIDTH-1];
              div_zero <= (OperandB == '0);
              is_div   <= MulDivOp[1];
            end else if (MulDivOp[1:0] == 2'b00) begin
              HI <= OperandA;
            end else if (MulDivOp[1:0] == 2'b01) begin
              LO <= OperandA;
            end
          end
        end
        MUL: begin
          acc     <= {mul_sum, acc[WIDTH-1:1]};
          counter <= counter + CW'(1);
        end
        DIV: begin
          rem     <= rem_nxt;
          acc     <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_bit};
          counter <= counter + CW'(1);
        end
        FIX: begin
          Done <= 1'b1;
          if (is_div) begin
            // Divide by zero reports the raw dividend, not its magnitude.
            if (div_zero) begin
              HI <= a_raw;
              LO <= '1;
            end else begin
              LO <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
              HI <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            end
          end else begin
            {HI, LO} <= neg_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// Self-checking bench for ex_muldiv_unit: directed vector table, random ops
// against an arithmetic reference model, and hand-written corner sequences.
module tb_ex_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset, Start, Flush;
  logic [2:0]  MulDivOp;
  logic [31:0] OperandA, OperandB;
  logic [31:0] HI, LO;
  logic        Busy, Done;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur_hi, cur_lo;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Flush(Flush),
    .MulDivOp(MulDivOp), .OperandA(OperandA), .OperandB(OperandB),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = cur_hi;
    lo = cur_lo;
    case (op)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 3'd2) begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end else begin
          hi = a % b; lo = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    @(negedge Clk);
    Start = 1'b1; Flush = fl; MulDivOp = op; OperandA = a; OperandB = b;
    @(negedge Clk);
    Start = 1'b0; Flush = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int busy_n;
    bit got;
    busy_n = 0;
    got    = 1'b0;
    issue(op, a, b, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (Done) begin got = 1'b1; break; end
      if (Busy) busy_n++;
      @(negedge Clk);
    end
    chk({name, " done_seen"}, 64'(got), 64'd1);
    chk({name, " busy_cycles"}, 64'(busy_n), 64'd33);
    chk({name, " busy_at_done"}, 64'(Busy), 64'd0);
    chk({name, " hi"}, 64'(HI), 64'(eh));
    chk({name, " lo"}, 64'(LO), 64'(el));
    @(negedge Clk);
    chk({name, " done_single"}, 64'(Done), 64'd0);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    logic [31:0] eh, el, ra, rb;
    logic [2:0]  rop;
    int          n, dseen;

    tbl[0] = '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{3'd3, 32'd7,          32'd0,          32'd7,          32'hFFFF_FFFF};
    tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{3'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    Reset = 1'b1; Start = 1'b0; Flush = 1'b0; MulDivOp = 3'd7; OperandA = '0; OperandB = '0;
    repeat (3) @(negedge Clk);
    chk("reset hi", 64'(HI), 64'd0);
    chk("reset lo", 64'(LO), 64'd0);
    chk("reset busy", 64'(Busy), 64'd0);
    chk("reset done", 64'(Done), 64'd0);
    Reset = 1'b0;
    cur_hi = '0;
    cur_lo = '0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(rop, ra, rb, eh, el);
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, eh, el);
    end

    issue(3'd4, 32'h0000_1234, 32'd0, 1'b0);
    chk("mthi hi", 64'(HI), 64'h1234);
    chk("mthi lo_kept", 64'(LO), 64'(cur_lo));
    chk("mthi busy", 64'(Busy), 64'd0);
    chk("mthi done", 64'(Done), 64'd0);
    cur_hi = 32'h0000_1234;
    issue(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
    chk("mtlo lo", 64'(LO), 64'hCAFE_F00D);
    chk("mtlo hi_kept", 64'(HI), 64'(cur_hi));
    cur_lo = 32'hCAFE_F00D;
    issue(3'd6, 32'h5555_5555, 32'd0, 1'b0);
    chk("noop busy", 64'(Busy), 64'd0);
    chk("noop hi", 64'(HI), 64'(cur_hi));

    issue(3'd0, 32'd5, 32'd6, 1'b1);
    chk("flush busy", 64'(Busy), 64'd0);
    dseen = 0;
    repeat (40) begin
      if (Done || Busy) dseen++;
      @(negedge Clk);
    end
    chk("flush no_activity", 64'(dseen), 64'd0);
    chk("flush hi", 64'(HI), 64'(cur_hi));
    chk("flush lo", 64'(LO), 64'(cur_lo));

    issue(3'd1, 32'd3, 32'd5, 1'b0);
    repeat (5) @(negedge Clk);
    Start = 1'b1; MulDivOp = 3'd3; OperandA = 32'd100; OperandB = 32'd7;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    while (!Done && n < 100) begin
      n++;
      @(negedge Clk);
    end
    chk("busy_start done_seen", 64'(Done), 64'd1);
    chk("busy_start hi", 64'(HI), 64'd0);
    chk("busy_start lo", 64'(LO), 64'd15);
    @(negedge Clk);
    chk("busy_start not_queued", 64'(Busy), 64'd0);
    cur_hi = 32'd0;
    cur_lo = 32'd15;

    issue(3'd3, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midreset busy", 64'(Busy), 64'd0);
    chk("midreset hi", 64'(HI), 64'd0);
    chk("midreset lo", 64'(LO), 64'd0);
    dseen = 0;
    repeat (40) begin
      if (Done) dseen++;
      @(negedge Clk);
    end
    chk("midreset no_done", 64'(dseen), 64'd0);
    cur_hi = '0;
    cur_lo = '0;

    model(3'd0, 32'hFFFF_FFF0, 32'h0000_0010, eh, el);
    run_op("post_reset mult", 3'd0, 32'hFFFF_FFF0, 32'h0000_0010, eh, el);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
